// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for the EX stage (shift-add / restoring divide).
// Optional macro MD_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply bypass the iteration.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            MD_clk,
   input  logic            MD_rst,
   input  logic            MD_start,
   input  logic            MD_is_div,
   input  logic [1:0]      MD_sel,
   input  logic [XLEN-1:0] MD_rs1,
   input  logic [XLEN-1:0] MD_rs2,
   input  logic [4:0]      MD_rd_in,
   input  logic            MD_flush,
   output logic            MD_stall,
   output logic            MD_done,
   output logic [XLEN-1:0] MD_result,
   output logic [4:0]      MD_rd_out
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

`ifdef MD_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [4:0]        count_q, count_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [4:0]        rd_out_q, rd_out_d;
   logic              dz_q, dz_d;
   logic              early_q, early_d;

   // Operation latch: only meaningful while an op is in flight.
   logic [XLEN-1:0]   a_mag_q, a_mag_d;
   logic [XLEN-1:0]   b_mag_q, b_mag_d;
   logic              a_neg_q, a_neg_d;
   logic              b_neg_q, b_neg_d;
   logic              is_div_q, is_div_d;
   logic [1:0]        sel_q, sel_d;
   logic [4:0]        rd_q, rd_d;

   logic              in_a_sgn, in_b_sgn, in_a_neg, in_b_neg, in_ovf, in_early;
   logic [XLEN-1:0]   in_a_mag, in_b_mag;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_sh, diff;
   logic [2*XLEN-1:0] div_next;

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   mul_res, quo_s, rem_s, rs1_orig, div_res;

   // Operand decode at acceptance: which operands are signed depends on the op.
   assign in_a_sgn = MD_is_div ? ~MD_sel[0] : (MD_sel != 2'b11);
   assign in_b_sgn = MD_is_div ? ~MD_sel[0] : ~MD_sel[1];
   assign in_a_neg = in_a_sgn & MD_rs1[XLEN-1];
   assign in_b_neg = in_b_sgn & MD_rs2[XLEN-1];
   assign in_a_mag = in_a_neg ? -MD_rs1 : MD_rs1;
   assign in_b_mag = in_b_neg ? -MD_rs2 : MD_rs2;
   assign in_ovf   = MD_is_div & ~MD_sel[0] & (MD_rs1 == MIN_NEG) & (MD_rs2 == '1);
   assign in_early = EARLY_EN & (MD_is_div ? ((MD_rs2 == '0) | in_ovf)
                                           : ((MD_rs1 == '0) | (MD_rs2 == '0)));

   // Multiply step: acc = {product_hi, multiplier}, add then shift right.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_mag_q : '0)};
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // Divide step: acc = {remainder, dividend/quotient}, shift left then trial subtract.
   assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign diff     = rem_sh - {1'b0, b_mag_q};
   assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

   // Sign fix-up of the unsigned magnitude results.
   assign prod_s   = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
   assign mul_res  = (sel_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
   assign quo_s    = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign rem_s    = a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
   assign rs1_orig = a_neg_q ? -a_mag_q : a_mag_q;
   assign div_res  = dz_q ? (sel_q[1] ? rs1_orig : '1)
                          : (sel_q[1] ? rem_s : quo_s);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      dz_d     = dz_q;
      early_d  = early_q;
      a_mag_d  = a_mag_q;
      b_mag_d  = b_mag_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      is_div_d = is_div_q;
      sel_d    = sel_q;
      rd_d     = rd_q;

      case (state_q)
         S_IDLE: begin
            if (MD_start && !MD_flush) begin
               is_div_d = MD_is_div;
               sel_d    = MD_sel;
               rd_d     = MD_rd_in;
               a_neg_d  = in_a_neg;
               b_neg_d  = in_b_neg;
               a_mag_d  = in_a_mag;
               b_mag_d  = in_b_mag;
               dz_d     = MD_is_div & (MD_rs2 == '0);
               early_d  = in_early;
               count_d  = 5'd31;
               acc_d    = {{XLEN{1'b0}}, (MD_is_div ? in_a_mag : in_b_mag)};
               state_d  = S_CALC;
               if (in_early) begin
                  // Preload the final unsigned result so FIX applies the normal sign rules.
                  acc_d   = in_ovf ? {{XLEN{1'b0}}, MIN_NEG} : '0;
                  state_d = S_FIX;
               end
            end
         end
         S_CALC: begin
            acc_d = is_div_q ? div_next : mul_next;
            if (count_q == 5'd0) state_d = S_FIX;
            else                 count_d = count_q - 5'd1;
         end
         S_FIX: begin
            result_d = is_div_q ? div_res : mul_res;
            rd_out_d = rd_q;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (MD_flush && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         result_d = result_q;
         rd_out_d = rd_out_q;
      end
   end

   always_ff @(posedge MD_clk) begin
      if (MD_rst) begin
         state_q  <= S_IDLE;
         count_q  <= 5'd0;
         acc_q    <= '0;
         result_q <= '0;
         rd_out_q <= 5'd0;
         dz_q     <= 1'b0;
         early_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
         dz_q     <= dz_d;
         early_q  <= early_d;
      end
   end

   always_ff @(posedge MD_clk) begin
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      is_div_q <= is_div_d;
      sel_q    <= sel_d;
      rd_q     <= rd_d;
   end

   assign MD_done   = (state_q == S_DONE);
   assign MD_stall  = ((state_q == S_IDLE) & MD_start) | (state_q == S_CALC)
                    | ((state_q == S_FIX) & ~early_q);
   assign MD_result = result_q;
   assign MD_rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: cycle-level reference model plus directed RV32M vectors.
module tb_ex_muldiv_unit;

`ifdef MD_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   localparam int SP_LAT = EARLY ? 1 : 33;

   logic        MD_clk, MD_rst, MD_start, MD_is_div, MD_flush;
   logic [1:0]  MD_sel;
   logic [31:0] MD_rs1, MD_rs2;
   logic [4:0]  MD_rd_in;
   logic        MD_stall, MD_done;
   logic [31:0] MD_result;
   logic [4:0]  MD_rd_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .MD_clk(MD_clk), .MD_rst(MD_rst), .MD_start(MD_start), .MD_is_div(MD_is_div),
      .MD_sel(MD_sel), .MD_rs1(MD_rs1), .MD_rs2(MD_rs2), .MD_rd_in(MD_rd_in),
      .MD_flush(MD_flush), .MD_stall(MD_stall), .MD_done(MD_done),
      .MD_result(MD_result), .MD_rd_out(MD_rd_out)
   );

   initial MD_clk = 1'b0;
   always #5 MD_clk = ~MD_clk;
   always @(posedge MD_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // RV32M result straight from the ISA definition.
   function automatic logic [31:0] ref_result(input logic dv, input logic [1:0] sel,
                                              input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      if (!dv) begin
         ea = (sel != 2'b11)  ? {{32{a[31]}}, a} : {32'b0, a};
         eb = (sel[1] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
         p  = ea * eb;
         return (sel == 2'b00) ? p[31:0] : p[63:32];
      end
      if (b == 32'h0) return sel[1] ? a : 32'hFFFFFFFF;
      if (!sel[0]) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) return sel[1] ? 32'h0 : a;
         return sel[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      end
      return sel[1] ? a % b : a / b;
   endfunction

   function automatic int ref_lat(input logic dv, input logic [1:0] sel,
                                  input logic [31:0] a, input logic [31:0] b);
      bit sp;
      sp = dv ? ((b == 32'h0) || (!sel[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))
              : ((a == 32'h0) || (b == 32'h0));
      return (sp && EARLY) ? 1 : 33;
   endfunction

   // Reference model: edges elapsed since the op was accepted.
   bit          m_busy = 1'b0;
   int          m_cnt = 0;
   int          m_lat = 33;
   logic [31:0] m_res = '0;
   logic [4:0]  m_rd = '0;
   logic [31:0] exp_result = '0;
   logic [4:0]  exp_rd = '0;

   always @(posedge MD_clk) begin
      if (MD_rst) begin
         m_busy = 1'b0;
         m_cnt = 0;
         exp_result = '0;
         exp_rd = '0;
      end else if (m_busy) begin
         if (MD_flush) m_busy = 1'b0;
         else begin
            m_cnt++;
            if (m_cnt == m_lat) begin
               exp_result = m_res;
               exp_rd = m_rd;
            end
            if (m_cnt > m_lat) m_busy = 1'b0;
         end
      end else if (MD_start && !MD_flush) begin
         m_busy = 1'b1;
         m_cnt = 0;
         m_res = ref_result(MD_is_div, MD_sel, MD_rs1, MD_rs2);
         m_lat = ref_lat(MD_is_div, MD_sel, MD_rs1, MD_rs2);
         m_rd = MD_rd_in;
      end
   end

   always @(negedge MD_clk) begin
      if (chk_en) begin
         chk("done", {31'b0, MD_done}, {31'b0, (m_busy && m_cnt == m_lat)});
         chk("stall", {31'b0, MD_stall},
             {31'b0, (m_busy ? ((m_lat > 1) && (m_cnt < m_lat)) : MD_start)});
         chk("result", MD_result, exp_result);
         chk("rd_out", {27'b0, MD_rd_out}, {27'b0, exp_rd});
      end
   end

   // Present an op for one edge; returns the cycle stamp of the accepting edge.
   task automatic issue(input logic dv, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, output int e0);
      MD_start = 1'b1;
      MD_is_div = dv;
      MD_sel = sel;
      MD_rs1 = a;
      MD_rs2 = b;
      MD_rd_in = rd;
      @(posedge MD_clk);
      #1;
      e0 = cyc;
      MD_start = 1'b0;
   endtask

   task automatic wait_check(input int e0, input logic [31:0] exp_res, input logic [4:0] exp_rdv,
                             input int exp_lat, input string name);
      bit seen = 1'b0;
      int lat = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge MD_clk);
         if (MD_done === 1'b1) begin
            seen = 1'b1;
            lat = cyc - e0;
         end
      end
      if (!seen) chk({name, "/timeout"}, 32'h0, 32'h1);
      else begin
         chk({name, "/latency"}, lat, exp_lat);
         chk({name, "/result"}, MD_result, exp_res);
         chk({name, "/rd"}, {27'b0, MD_rd_out}, {27'b0, exp_rdv});
      end
      @(posedge MD_clk);
      #1;
   endtask

   task automatic run_op(input logic dv, input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                         input int exp_lat, input string name);
      int e0;
      issue(dv, sel, a, b, rd, e0);
      wait_check(e0, exp_res, rd, exp_lat, name);
   endtask

   initial begin
      int e0;
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
      e0 = 0;
   end

   initial begin
      int e0;
      MD_rst = 1'b1;
      MD_start = 1'b0;
      MD_is_div = 1'b0;
      MD_sel = 2'b00;
      MD_rs1 = '0;
      MD_rs2 = '0;
      MD_rd_in = '0;
      MD_flush = 1'b0;
      repeat (2) @(posedge MD_clk);
      #1;
      MD_rst = 1'b0;
      chk_en = 1'b1;
      chk("reset/done", {31'b0, MD_done}, 32'h0);
      chk("reset/result", MD_result, 32'h0);
      chk("reset/rd", {27'b0, MD_rd_out}, 32'h0);
      chk("reset/stall", {31'b0, MD_stall}, 32'h0);

      run_op(1'b0, 2'b00, 32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33, "mul");
      run_op(1'b0, 2'b01, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33, "mulh");
      run_op(1'b0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33, "mulhu");
      run_op(1'b0, 2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'hFFFFFFFF, 33, "mulhsu");
      run_op(1'b1, 2'b00, 32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFD, 33, "div");
      run_op(1'b1, 2'b10, 32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF, 33, "rem");
      run_op(1'b1, 2'b01, 32'h00000005, 32'h00000000, 5'd7,  32'hFFFFFFFF, SP_LAT, "divu_dz");
      run_op(1'b1, 2'b11, 32'h00000005, 32'h00000000, 5'd8,  32'h00000005, SP_LAT, "remu_dz");
      run_op(1'b1, 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, SP_LAT, "div_ovf");
      run_op(1'b1, 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, SP_LAT, "rem_ovf");
      run_op(1'b0, 2'b00, 32'h00000000, 32'h00012345, 5'd11, 32'h00000000, SP_LAT, "mul_zero");
      run_op(1'b1, 2'b00, 32'hFFFFFFF9, 32'h00000000, 5'd12, 32'hFFFFFFFF, SP_LAT, "div_dz");
      run_op(1'b1, 2'b10, 32'hFFFFFFF9, 32'h00000000, 5'd14, 32'hFFFFFFF9, SP_LAT, "rem_dz");
      run_op(1'b0, 2'b00, 32'h0000C350, 32'h0000C350, 5'd15, 32'h9502F900, 33, "mul_big");

      // Flush mid-divide, then the same divide runs to completion.
      issue(1'b1, 2'b01, 32'd100, 32'd7, 5'd5, e0);
      repeat (9) @(posedge MD_clk);
      #1 MD_flush = 1'b1;
      @(posedge MD_clk);
      #1 MD_flush = 1'b0;
      chk("flush/stall", {31'b0, MD_stall}, 32'h0);
      chk("flush/done", {31'b0, MD_done}, 32'h0);
      chk("flush/result", MD_result, 32'h9502F900);
      repeat (40) @(posedge MD_clk);
      #1;
      run_op(1'b1, 2'b01, 32'd100, 32'd7, 5'd5, 32'h0000000E, 33, "divu_after_flush");

      // Start with flush in IDLE is refused.
      MD_start = 1'b1;
      MD_flush = 1'b1;
      MD_is_div = 1'b0;
      MD_rs1 = 32'd9;
      MD_rs2 = 32'd9;
      MD_rd_in = 5'd30;
      @(posedge MD_clk);
      #1;
      MD_start = 1'b0;
      MD_flush = 1'b0;
      repeat (40) @(posedge MD_clk);
      #1;
      chk("start_flush/rd", {27'b0, MD_rd_out}, 32'd5);

      // Reset in the middle of a multiply, then a fresh op on the next edge.
      issue(1'b0, 2'b00, 32'd123, 32'd456, 5'd20, e0);
      repeat (14) @(posedge MD_clk);
      #1 MD_rst = 1'b1;
      @(posedge MD_clk);
      #1 MD_rst = 1'b0;
      chk("midrst/result", MD_result, 32'h0);
      chk("midrst/rd", {27'b0, MD_rd_out}, 32'h0);
      chk("midrst/done", {31'b0, MD_done}, 32'h0);
      chk("midrst/stall", {31'b0, MD_stall}, 32'h0);
      run_op(1'b0, 2'b00, 32'd6, 32'd7, 5'd13, 32'd42, 33, "mul_after_rst");

      // A second start while busy is ignored.
      issue(1'b0, 2'b00, 32'd3, 32'd5, 5'd2, e0);
      repeat (4) @(posedge MD_clk);
      #1;
      MD_start = 1'b1;
      MD_rs1 = 32'd100;
      MD_rs2 = 32'd100;
      MD_rd_in = 5'd9;
      @(posedge MD_clk);
      #1 MD_start = 1'b0;
      wait_check(e0, 32'd15, 5'd2, 33, "ignore_busy_start");
      repeat (40) @(posedge MD_clk);
      #1;
      chk("ignore/hold_result", MD_result, 32'd15);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
